uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_gen.sv | 95 +++++++++
 tb/tb_uart_baud_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// UART baud/tick generator: oversample, mid-bit and bit-period strobes from a 3-bit baud select.
// Divisors are elaboration-time constants; a resync or a baud change reloads the bit timing at once.
module uart_baud_gen #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud,
  input  logic       enable,
  input  logic       resync,
  output logic       os_tick,
  output logic       mid_tick,
  output logic       bit_tick,
  output logic       running
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  typedef logic [7:0][DIV_W-1:0] div_table_t;

  function automatic int baud_rate(input int sel);
    int r;
    case (sel)
      0:       r = 1200;
      1:       r = 2400;
      2:       r = 4800;
      3:       r = 9600;
      4:       r = 19200;
      5:       r = 38400;
      6:       r = 57600;
      default: r = 115200;
    endcase
    return r;
  endfunction

  // Each entry holds D-1, the value loaded into div_cnt (round-half-up divisor).
  function automatic div_table_t build_div_table();
    div_table_t t;
    int         den;
    for (int i = 0; i < 8; i++) begin
      den  = baud_rate(i) * OVERSAMPLE;
      t[i] = DIV_W'(((CLK_FREQ + den / 2) / den) - 1);
    end
    return t;
  endfunction

  localparam div_table_t DIV_M1 = build_div_table();
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [2:0]       baud_q;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q   <= 3'b001;
      div_cnt  <= DIV_M1[1];
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      running  <= 1'b0;
    end else begin
      running <= enable && !resync && (baud == baud_q);
      if (resync || (baud != baud_q)) begin
        // Fresh bit timing at the (possibly new) rate; nothing from the old phase survives.
        baud_q   <= baud;
        div_cnt  <= DIV_M1[baud];
        os_cnt   <= '0;
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
      end else if (!enable) begin
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
      end else if (div_cnt == '0) begin
        div_cnt  <= DIV_M1[baud_q];
        os_tick  <= 1'b1;
        mid_tick <= (os_cnt == OS_MID);
        bit_tick <= (os_cnt == OS_LAST);
        os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      end else begin
        div_cnt  <= div_cnt - DIV_W'(1);
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at 50 MHz: tick latencies, rate change, resync, enable hold, async reset.
module tb_uart_baud_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud;
  logic       enable;
  logic       resync;
  logic       os_tick;
  logic       mid_tick;
  logic       bit_tick;
  logic       running;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int n;
  int seen;

  localparam int BUDGET = 30000;

  uart_baud_gen dut (
    .clk      (clk),
    .rst      (rst),
    .baud     (baud),
    .enable   (enable),
    .resync   (resync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .running  (running)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if ((bit_tick && mid_tick) || (bit_tick && !os_tick) || (mid_tick && !os_tick))
        viol++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Counts rising edges until the selected tick (0=os, 1=mid, 2=bit) is seen; -1 if it never comes.
  task automatic wait_tick(input int sel, output int cnt);
    logic hit;
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < BUDGET) begin
      @(posedge clk);
      #1;
      cnt++;
      hit = (sel == 0) ? os_tick : (sel == 1) ? mid_tick : bit_tick;
    end
    if (!hit) cnt = -1;
  endtask

  initial begin
    #2000000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    baud   = 3'b001;
    resync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_os", int'(os_tick), 0);
    check("rst_mid", int'(mid_tick), 0);
    check("rst_bit", int'(bit_tick), 0);
    check("rst_running", int'(running), 0);

    // Scenario 1: baud 001, D=1302
    rst = 1'b0;
    wait_tick(0, n); check("s1_first_os", n, 1302);
    check("s1_running", int'(running), 1);
    wait_tick(0, n); check("s1_os_period", n, 1302);
    wait_tick(1, n); check("s1_mid", n, 7812);
    wait_tick(2, n); check("s1_first_bit", n, 10416);
    wait_tick(2, n); check("s1_bit_period", n, 20832);

    // Scenario 2: baud 111, D=27
    baud = 3'b111;
    @(posedge clk); #1;
    check("s2_chg_running", int'(running), 0);
    check("s2_chg_os", int'(os_tick), 0);
    wait_tick(0, n); check("s2_first_os", n, 27);
    check("s2_running", int'(running), 1);
    wait_tick(1, n); check("s2_first_mid", n, 189);
    wait_tick(2, n); check("s2_first_bit", n, 216);
    for (int b = 0; b < 4; b++) begin
      wait_tick(1, n); check("s2_mid", n, 216);
      wait_tick(2, n); check("s2_bit", n, 216);
    end

    // Scenario 3: mid-bit change 111 -> 011 on the edge that would have ticked
    wait_tick(0, n); check("s3_os_before", n, 27);
    repeat (26) @(posedge clk);
    #1;
    baud = 3'b011;
    @(posedge clk); #1;
    check("s3_chg_os", int'(os_tick), 0);
    check("s3_chg_mid", int'(mid_tick), 0);
    check("s3_chg_bit", int'(bit_tick), 0);
    check("s3_chg_running", int'(running), 0);
    wait_tick(0, n); check("s3_first_os", n, 326);
    check("s3_running", int'(running), 1);
    wait_tick(2, n); check("s3_first_bit", n, 4890);

    // Scenario 4: baud 101 (D=81), resync at os_cnt=9
    baud = 3'b101;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      wait_tick(0, n); check("s4_os", n, 81);
    end
    repeat (20) @(posedge clk);
    #1;
    resync = 1'b1;
    @(posedge clk); #1;
    resync = 1'b0;
    check("s4_rs_running", int'(running), 0);
    check("s4_rs_os", int'(os_tick), 0);
    wait_tick(1, n); check("s4_mid", n, 648);
    wait_tick(2, n); check("s4_bit", n, 648);

    // Scenario 5: enable low for 100 cycles with div_cnt=10, os_cnt=1
    wait_tick(0, n); check("s5_os", n, 81);
    repeat (70) @(posedge clk);
    #1;
    enable = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      seen += int'(os_tick) + int'(mid_tick) + int'(bit_tick);
    end
    check("s5_ticks_low", seen, 0);
    check("s5_running_low", int'(running), 0);
    enable = 1'b1;
    wait_tick(0, n); check("s5_resume_os", n, 11);
    wait_tick(1, n); check("s5_phase_mid", n, 486);

    // Scenario 6: async reset between edges while os_tick is high
    wait_tick(0, n); check("s6_os", n, 81);
    #2;
    rst = 1'b1;
    #1;
    check("s6_rst_os", int'(os_tick), 0);
    check("s6_rst_mid", int'(mid_tick), 0);
    check("s6_rst_bit", int'(bit_tick), 0);
    check("s6_rst_running", int'(running), 0);
    baud = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_tick(0, n); check("s6_first_os", n, 1302);
    wait_tick(0, n); check("s6_os_period", n, 1302);
    wait_tick(1, n); check("s6_mid", n, 7812);
    wait_tick(2, n); check("s6_first_bit", n, 10416);

    check("coincidence", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
